// File: rtl/pcs_blk_frame_gen.sv
// 64b/66b frame generator: START, N DATA, TERM and G IDLE blocks per frame,
// presented on a valid/ready stream with run/stop control and a frame counter.
module pcs_blk_frame_gen #(
  parameter int          LEN_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [30:0] PRBS_SEED = 31'h7FFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_payload_blks,
  input  logic [LEN_W-1:0] cfg_gap_blks,
  input  logic [CNT_W-1:0] cfg_num_frames,
  input  logic [63:0]      cfg_fixed,
  output logic [65:0]      blk_o,
  output logic             blk_vld,
  input  logic             blk_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             done
);

  localparam logic [65:0] BLK_START = {2'b10, 64'hD555555555555578};
  localparam logic [65:0] BLK_TERM  = {2'b10, 64'h0000000000000087};
  localparam logic [65:0] BLK_IDLE  = {2'b10, 64'h000000000000001E};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_TERM  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // PRBS31 (x^31+x^28+1), 64 bits MSB-first; returns {next_state, word}.
  function automatic logic [94:0] prbs_step64(input logic [30:0] seed);
    logic [30:0] s;
    logic [63:0] w;
    logic        b;
    s = seed;
    w = {64{1'b0}};
    for (int j = 63; j >= 0; j--) begin
      b    = s[30] ^ s[27];
      w[j] = b;
      s    = {s[29:0], b};
    end
    return {s, w};
  endfunction

  state_t           state_r;
  logic             armed_r;
  logic [30:0]      prbs_r;
  logic [7:0]       base_r;
  logic [LEN_W-1:0] data_cnt_r;
  logic [LEN_W-1:0] gap_cnt_r;
  logic [LEN_W-1:0] lat_payload_r;
  logic [LEN_W-1:0] lat_gap_r;
  logic [1:0]       lat_mode_r;
  logic [CNT_W-1:0] lat_num_r;
  logic [63:0]      lat_fixed_r;

  logic             xfer_s;
  logic [94:0]      prbs_res_s;
  logic [63:0]      inc_word_s;
  logic [63:0]      payload_s;
  logic [CNT_W-1:0] frame_inc_s;
  logic             term_last_s;
  logic             start_s;

  // Payload word for the next DATA block and the frame-entry decision.
  always_comb begin
    xfer_s      = blk_vld && blk_rdy;
    prbs_res_s  = prbs_step64(prbs_r);
    inc_word_s  = {64{1'b0}};
    for (int k = 0; k < 8; k++) begin
      inc_word_s[8*k +: 8] = base_r + 8'(k);
    end
    case (lat_mode_r)
      2'd0:    payload_s = inc_word_s;
      2'd1:    payload_s = prbs_res_s[63:0];
      default: payload_s = lat_fixed_r;
    endcase
    frame_inc_s = frame_cnt + CNT_ONE;
    term_last_s = (lat_num_r != CNT_ZERO) && (frame_inc_s == lat_num_r);
    case (state_r)
      S_OFF:   start_s = cfg_en && armed_r;
      S_TERM:  start_s = xfer_s && !term_last_s && cfg_en && (lat_gap_r == LEN_ZERO);
      S_GAP:   start_s = xfer_s && (gap_cnt_r == lat_gap_r) && cfg_en;
      default: start_s = 1'b0;
    endcase
  end

  // Frame sequencer; every output is driven from this register set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_OFF;
      armed_r       <= 1'b1;
      prbs_r        <= PRBS_SEED;
      base_r        <= 8'd0;
      data_cnt_r    <= LEN_ZERO;
      gap_cnt_r     <= LEN_ZERO;
      lat_payload_r <= LEN_ZERO;
      lat_gap_r     <= LEN_ZERO;
      lat_mode_r    <= 2'd0;
      lat_num_r     <= CNT_ZERO;
      lat_fixed_r   <= 64'd0;
      blk_o         <= 66'd0;
      blk_vld       <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= CNT_ZERO;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!cfg_en) begin
        armed_r <= 1'b1;
      end else if (state_r == S_OFF && start_s) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end

      case (state_r)
        S_OFF: begin
          blk_vld <= 1'b0;
          busy    <= 1'b0;
          if (start_s) begin
            frame_cnt <= CNT_ZERO;
          end
        end
        S_START: begin
          if (xfer_s) begin
            if (lat_payload_r != LEN_ZERO) begin
              state_r    <= S_DATA;
              blk_o      <= {2'b01, payload_s};
              base_r     <= base_r + 8'd8;
              data_cnt_r <= data_cnt_r + LEN_ONE;
              if (lat_mode_r == 2'd1) begin
                prbs_r <= prbs_res_s[94:64];
              end
            end else begin
              state_r <= S_TERM;
              blk_o   <= BLK_TERM;
            end
          end
        end
        S_DATA: begin
          if (xfer_s) begin
            if (data_cnt_r == lat_payload_r) begin
              state_r <= S_TERM;
              blk_o   <= BLK_TERM;
            end else begin
              blk_o      <= {2'b01, payload_s};
              base_r     <= base_r + 8'd8;
              data_cnt_r <= data_cnt_r + LEN_ONE;
              if (lat_mode_r == 2'd1) begin
                prbs_r <= prbs_res_s[94:64];
              end
            end
          end
        end
        S_TERM: begin
          if (xfer_s) begin
            frame_cnt <= frame_inc_s;
            if (term_last_s || !cfg_en) begin
              state_r <= S_OFF;
              blk_vld <= 1'b0;
              busy    <= 1'b0;
              done    <= term_last_s;
            end else if (lat_gap_r != LEN_ZERO) begin
              state_r   <= S_GAP;
              blk_o     <= BLK_IDLE;
              gap_cnt_r <= LEN_ONE;
            end else begin
              state_r <= S_START;
            end
          end
        end
        S_GAP: begin
          if (xfer_s) begin
            if (gap_cnt_r != lat_gap_r) begin
              gap_cnt_r <= gap_cnt_r + LEN_ONE;
            end else if (!cfg_en) begin
              state_r <= S_OFF;
              blk_vld <= 1'b0;
              busy    <= 1'b0;
            end else begin
              state_r <= S_START;
            end
          end
        end
        default: begin
          state_r <= S_OFF;
          blk_vld <= 1'b0;
          busy    <= 1'b0;
        end
      endcase

      // Frame entry overrides the case above; config is sampled only here.
      if (start_s) begin
        state_r       <= S_START;
        blk_o         <= BLK_START;
        blk_vld       <= 1'b1;
        busy          <= 1'b1;
        base_r        <= 8'd0;
        data_cnt_r    <= LEN_ZERO;
        lat_payload_r <= cfg_payload_blks;
        lat_gap_r     <= cfg_gap_blks;
        lat_mode_r    <= cfg_mode;
        lat_num_r     <= cfg_num_frames;
        lat_fixed_r   <= cfg_fixed;
      end
    end
  end

endmodule

// File: tb/tb_pcs_blk_frame_gen.sv
// Directed bench for pcs_blk_frame_gen: frame sequences, stalls, PRBS payload,
// graceful stop, restart and asynchronous reset.
module tb_pcs_blk_frame_gen;

  localparam logic [65:0] B_START = {2'b10, 64'hD555555555555578};
  localparam logic [65:0] B_TERM  = {2'b10, 64'h0000000000000087};
  localparam logic [65:0] B_IDLE  = {2'b10, 64'h000000000000001E};
  localparam logic [65:0] B_D0    = {2'b01, 64'h0706050403020100};
  localparam logic [65:0] B_D1    = {2'b01, 64'h0F0E0D0C0B0A0908};

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_payload_blks;
  logic [7:0]  cfg_gap_blks;
  logic [15:0] cfg_num_frames;
  logic [63:0] cfg_fixed;
  logic [65:0] blk_o;
  logic        blk_vld;
  logic        blk_rdy;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [65:0] acc[$];
  logic [65:0] want[$];
  int done_cnt, stab_err, first_idx, last_idx;

  pcs_blk_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
    .cfg_payload_blks(cfg_payload_blks), .cfg_gap_blks(cfg_gap_blks),
    .cfg_num_frames(cfg_num_frames), .cfg_fixed(cfg_fixed),
    .blk_o(blk_o), .blk_vld(blk_vld), .blk_rdy(blk_rdy), .busy(busy),
    .frame_cnt(frame_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic prbs_model(input logic [30:0] si, output logic [63:0] w, output logic [30:0] so);
    logic b;
    so = si;
    for (int j = 63; j >= 0; j--) begin
      b = so[30] ^ so[27];
      w[j] = b;
      so = {so[29:0], b};
    end
  endtask

  // Runs a fixed number of cycles, recording accepted blocks and stall stability.
  task automatic collect(input int cycles, input bit rand_rdy, input int drop_at);
    logic cv, cr;
    logic [65:0] cb;
    acc.delete();
    done_cnt = 0; stab_err = 0; first_idx = -1; last_idx = -1;
    for (int c = 0; c < cycles; c++) begin
      blk_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (drop_at >= 0 && acc.size() == drop_at && blk_vld) cfg_en = 1'b0;
      cv = blk_vld; cr = blk_rdy; cb = blk_o;
      @(posedge clk); #1;
      if (cv && cr) begin
        acc.push_back(cb);
        if (first_idx < 0) first_idx = c;
        last_idx = c;
      end
      if (cv && !cr && (!blk_vld || blk_o !== cb)) stab_err++;
      if (done) done_cnt++;
    end
    blk_rdy = 1'b1;
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] p, input logic [7:0] g, input logic [15:0] n);
    cfg_mode = m; cfg_payload_blks = p; cfg_gap_blks = g; cfg_num_frames = n;
    cfg_fixed = 64'hDEADBEEFCAFEF00D;
  endtask

  task automatic stop_idle();
    cfg_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_en = 1'b0; blk_rdy = 1'b1;
    setup(2'd0, 8'd2, 8'd1, 16'd1);
    repeat (2) @(posedge clk);
    #1;
    total++; if (blk_o !== 66'd0) begin bad++; $display("FAIL reset_blk got=%h want=0", blk_o); end
    total++; if ({blk_vld, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {blk_vld, busy, done}); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_seq(input string nm);
    total++;
    if (acc.size() != want.size()) begin
      bad++; $display("FAIL %s_len got=%0d want=%0d", nm, acc.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < acc.size(); i++) begin
      total++;
      if (acc[i] !== want[i]) begin bad++; $display("FAIL %s_blk%0d got=%h want=%h", nm, i, acc[i], want[i]); end
    end
  endtask

  task automatic test_single_frame();
    setup(2'd0, 8'd2, 8'd1, 16'd1);
    cfg_en = 1'b1;
    collect(20, 1'b0, -1);
    want = '{B_START, B_D0, B_D1, B_TERM};
    check_seq("single");
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done got=%0d want=1", done_cnt); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt got=%0d want=1", frame_cnt); end
    total++; if ({blk_vld, busy} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b want=00", {blk_vld, busy}); end
    stop_idle();
  endtask

  task automatic test_backpressure();
    setup(2'd0, 8'd2, 8'd1, 16'd1);
    cfg_en = 1'b1;
    collect(80, 1'b1, -1);
    want = '{B_START, B_D0, B_D1, B_TERM};
    check_seq("stall");
    total++; if (stab_err != 0) begin bad++; $display("FAIL stall_stable got=%0d want=0", stab_err); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
    stop_idle();
  endtask

  task automatic test_back_to_back();
    setup(2'd0, 8'd0, 8'd0, 16'd3);
    cfg_en = 1'b1;
    collect(20, 1'b0, -1);
    want = '{B_START, B_TERM, B_START, B_TERM, B_START, B_TERM};
    check_seq("b2b");
    total++; if (last_idx - first_idx + 1 != 6) begin bad++; $display("FAIL b2b_span got=%0d want=6", last_idx - first_idx + 1); end
    total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL b2b_frame_cnt got=%0d want=3", frame_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done got=%0d want=1", done_cnt); end
    stop_idle();
  endtask

  task automatic test_prbs();
    logic [30:0] s;
    logic [63:0] w;
    rst_n = 1'b0; cfg_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    setup(2'd1, 8'd4, 8'd1, 16'd2);
    cfg_en = 1'b1;
    collect(30, 1'b0, -1);
    s = 31'h7FFFFFFF;
    want.delete();
    for (int f = 0; f < 2; f++) begin
      if (f == 1) want.push_back(B_IDLE);
      want.push_back(B_START);
      for (int i = 0; i < 4; i++) begin
        prbs_model(s, w, s);
        want.push_back({2'b01, w});
      end
      want.push_back(B_TERM);
    end
    check_seq("prbs");
    stop_idle();
  endtask

  task automatic test_graceful_stop();
    setup(2'd0, 8'd2, 8'd1, 16'd0);
    cfg_en = 1'b1;
    collect(40, 1'b0, 22);
    total++; if (acc.size() != 24) begin bad++; $display("FAIL stop_len got=%0d want=24", acc.size()); end
    if (acc.size() == 24) begin
      total++; if (acc[20] !== B_START) begin bad++; $display("FAIL stop_f5_start got=%h want=%h", acc[20], B_START); end
      total++; if (acc[22] !== B_D1) begin bad++; $display("FAIL stop_f5_d1 got=%h want=%h", acc[22], B_D1); end
      total++; if (acc[23] !== B_TERM) begin bad++; $display("FAIL stop_f5_term got=%h want=%h", acc[23], B_TERM); end
    end
    total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL stop_frame_cnt got=%0d want=5", frame_cnt); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL stop_no_done got=%0d want=0", done_cnt); end
    total++; if ({blk_vld, busy} !== 2'b00) begin bad++; $display("FAIL stop_off got=%b want=00", {blk_vld, busy}); end
    stop_idle();
    setup(2'd0, 8'd2, 8'd1, 16'd1);
    cfg_en = 1'b1;
    @(posedge clk); #1;
    total++; if (blk_vld !== 1'b1 || blk_o !== B_START) begin bad++; $display("FAIL restart_start got=%b/%h want=1/%h", blk_vld, blk_o, B_START); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL restart_frame_cnt got=%0d want=0", frame_cnt); end
    collect(20, 1'b0, -1);
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL restart_end_cnt got=%0d want=1", frame_cnt); end
    stop_idle();
  endtask

  task automatic test_async_reset();
    int n;
    setup(2'd0, 8'd4, 8'd0, 16'd0);
    cfg_en = 1'b1;
    n = 0;
    while (!(frame_cnt == 16'd2 && blk_vld && blk_o[65:64] == 2'b01) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++; if (n >= 100) begin bad++; $display("FAIL arst_wait got=timeout want=data_in_frame3"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (blk_vld !== 1'b0) begin bad++; $display("FAIL arst_vld got=%b want=0", blk_vld); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL arst_frame_cnt got=%0d want=0", frame_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    collect(5, 1'b0, -1);
    total++;
    if (acc.size() == 0) begin bad++; $display("FAIL arst_first got=none want=%h", B_START); end
    else if (acc[0] !== B_START) begin bad++; $display("FAIL arst_first got=%h want=%h", acc[0], B_START); end
    stop_idle();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_prbs();
    test_graceful_stop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcs_blk_frame_gen.md
Name: pcs_blk_frame_gen

Overview:
Parametrised 64b/66b block-stream test generator for the low-latency PCS datapath. It emits Ethernet-like frames as 66-bit blocks: a start block, N data blocks and a terminate block, each frame followed by G idle blocks. Payload length, gap, frame count and payload mode are set at run time. Output uses a full valid/ready handshake and feeds the PCS TX scrambler/gearbox input or a loopback checker.

Parameters:
LEN_W, 8, width of cfg_payload_blks and cfg_gap_blks
CNT_W, 16, width of cfg_num_frames and frame_cnt
PRBS_SEED, 31'h7FFFFFFF, PRBS31 state after reset; must be nonzero

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_en  input  1  run enable; a run starts on the rising edge, and deassertion requests a graceful stop
cfg_mode  input  2  0=incrementing bytes, 1=PRBS31, 2/3=fixed cfg_fixed
cfg_payload_blks  input  LEN_W  data blocks per frame, 0 allowed
cfg_gap_blks  input  LEN_W  idle blocks after each frame, 0 allowed
cfg_num_frames  input  CNT_W  frames per run; 0 means unlimited
cfg_fixed  input  64  payload word for mode 2/3
blk_o  output  66  {sync[1:0], block[63:0]}, type byte at bits [7:0]
blk_vld  output  1  blk_o valid
blk_rdy  input  1  downstream ready
busy  output  1  state is not OFF
frame_cnt  output  CNT_W  terminate blocks accepted in the current run
done  output  1  one-cycle pulse when cfg_num_frames have completed

Behaviour:
- Reset values: blk_o=0, blk_vld=0, busy=0, frame_cnt=0, done=0, state=OFF, PRBS=PRBS_SEED, armed=1.
- Block encodings:
  - START = {2'b10, 64'hD555555555555578}
  - DATA = {2'b01, payload}
  - TERM = {2'b10, 64'h0000000000000087}
  - IDLE = {2'b10, 64'h000000000000001E}
- Handshake:
  - A transfer occurs when blk_vld && blk_rdy.
  - While blk_vld=1 and blk_rdy=0, blk_o holds stable.
  - Counters and PRBS advance only on a transfer.
  - Outputs are registered.
- States: OFF, START, DATA, TERM, GAP.
  - OFF: blk_vld=0. If cfg_en=1 and armed=1, the next cycle enters START: blk_o=START, blk_vld=1, frame_cnt cleared. cfg_payload_blks, cfg_gap_blks, cfg_mode, cfg_num_frames and cfg_fixed are latched at this point. armed is cleared when a run starts and set whenever cfg_en=0 is sampled.
  - START transfer: go to DATA if payload>0, else TERM. The byte-incrementing base resets to 0.
  - DATA: emit payload blocks. After the payload-th transfer, go to TERM.
  - TERM transfer: frame_cnt+1 (wraps).
    - If cfg_num_frames!=0 and new frame_cnt==cfg_num_frames: go to OFF and pulse done the same cycle blk_vld drops.
    - Else if cfg_en=0: go to OFF with no done pulse.
    - Else: go to GAP if gap>0, otherwise directly to START (back-to-back frames, no bubble).
  - GAP: emit IDLE. After the gap-th transfer, go to START if cfg_en=1, else OFF. Config is re-latched at each START entry.
- Graceful stop: cfg_en=0 mid-frame never truncates a frame. DATA and TERM complete, then the block goes to OFF after TERM, or at the end of GAP if the drop occurs there.
- Payload modes:
  - Mode 0: byte k of data block i (k=0 at bits[7:0]) = (8*i+k) mod 256, with i counted from 0 per frame.
  - Mode 1: PRBS31 (x^31+x^28+1), 64 bits per block, generated MSB-first into bits[63:0]. State advances 64 steps per DATA transfer and continues across frames and runs; it is reloaded only by reset.
  - Mode 2/3: cfg_fixed.
- Changes to cfg_* outside the latch point have no effect on the frame in flight.
- Reset mid-operation: all state returns to reset values immediately (asynchronously); there is no partial-frame completion.

Test Plan:
- mode0, payload=2, gap=1, num=1, blk_rdy=1 -> START, DATA 64'h0706050403020100, DATA 64'h0F0E0D0C0B0A0908, TERM, then OFF. done pulses once, frame_cnt=1, the IDLE is not emitted.
- Same config with blk_rdy toggling randomly at 50% -> blk_o stable whenever vld&&!rdy, identical accepted sequence, no dropped or duplicated blocks.
- payload=0, gap=0, num=3 -> accepted stream START,TERM,START,TERM,START,TERM with blk_vld continuously 1, frame_cnt=3, one done pulse.
- mode1, payload=4, num=2 -> the 8 DATA words match a reference PRBS31 model seeded at PRBS_SEED and continuous across the two frames.
- num=0, cfg_en dropped in the 2nd DATA of frame 5 -> frame 5 completes through TERM, then OFF with no done and frame_cnt=5. Re-raising cfg_en starts a new run with frame_cnt=0.
- rst_n asserted during DATA -> blk_vld=0 and frame_cnt=0 asynchronously. After release with cfg_en held high, the first accepted block is START.
